// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: RV32 MEM-stage data memory with valid/ready port, wait states and misalignment errors
module data_mem_ctrl #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);
    localparam int DEPTH = 2 ** (ADDR_W - 2);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
    logic [31:0] mem [DEPTH];
    logic [1:0] state;
    logic [3:0] cnt;
    logic [ADDR_W-1:0] lat_addr, ld_addr;
    logic [1:0] lat_size, ld_size;
    logic lat_unsigned, lat_we, lat_err, ld_unsigned, ld_we, ld_err;
    logic accept, acc_err, to_resp;
    logic [3:0] be;
    logic [31:0] wd, word, ld_data;
    logic [7:0] ld_byte;
    logic [15:0] ld_half;

    function automatic logic misaligned(input logic [1:0] a, input logic [1:0] s);
        return s == 2'b11 || (s == 2'b01 && a[0]) || (s == 2'b10 && a != 2'b00);
    endfunction

    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign accept = req_ready && req_valid;
    assign acc_err = misaligned(req_addr[1:0], req_size);
    assign to_resp = (accept && WAIT_STATES == 0) || (state == WAIT && cnt == 4'd0);
    // With no wait states the response is formed on the accept edge, so the live request is used
    assign ld_addr = req_ready ? req_addr : lat_addr;
    assign ld_size = req_ready ? req_size : lat_size;
    assign ld_unsigned = req_ready ? req_unsigned : lat_unsigned;
    assign ld_we = req_ready ? req_we : lat_we;
    assign ld_err = req_ready ? acc_err : lat_err;

    always_comb begin
        be = req_size == 2'b00 ? 4'b0001 << req_addr[1:0] : req_size == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd = req_size == 2'b00 ? {4{req_wdata[7:0]}} : req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
        word = mem[ld_addr[ADDR_W-1:2]];
        ld_byte = word[{ld_addr[1:0], 3'b000} +: 8];
        ld_half = ld_addr[1] ? word[31:16] : word[15:0];
        ld_data = ld_size == 2'b00 ? {{24{!ld_unsigned && ld_byte[7]}}, ld_byte} :
                  ld_size == 2'b01 ? {{16{!ld_unsigned && ld_half[15]}}, ld_half} : word;
    end

    always_ff @(posedge clk)
        if (accept && req_we && !acc_err)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[req_addr[ADDR_W-1:2]][8*i +: 8] <= wd[8*i +: 8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_err <= 1'b0;
            lat_addr <= '0;
            lat_size <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_we <= 1'b0;
            lat_err <= 1'b0;
        end else begin
            state <= to_resp ? RESP : accept ? WAIT : state == RESP ? IDLE : state;
            cnt <= accept ? CNT_INIT : (state == WAIT && cnt != 4'd0) ? cnt - 4'd1 : cnt;
            rsp_rdata <= (to_resp && !ld_we && !ld_err) ? ld_data : 32'd0;
            rsp_err <= to_resp && ld_err;
            lat_addr <= accept ? req_addr : lat_addr;
            lat_size <= accept ? req_size : lat_size;
            lat_unsigned <= accept ? req_unsigned : lat_unsigned;
            lat_we <= accept ? req_we : lat_we;
            lat_err <= accept ? acc_err : lat_err;
        end
    end
endmodule
